// File: rtl/uart_rx_if.sv
// uart_rx serial-side and consumer-side signals: rx line in, byte plus set/reset ready flag out.
// master drives rx/clr_rdy (line model or link), slave is the receiver.
interface uart_rx_if;
  logic       rx;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;

  modport master (output rx, clr_rdy, input rx_data, rdy, frm_err);
  modport slave  (input rx, clr_rdy, output rx_data, rdy, frm_err);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver; rdy/rx_data valid 1 clk after the mid-stop-bit sample, no backpressure (overrun overwrites).
// Optional UART_RX_MAJ_VOTE_EN: 2-of-3 vote of rx_s at baud_cnt 2,1,0 instead of a single sample.
module uart_rx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int          HALF_DIV = BAUD_DIV / 2;
  localparam logic [11:0] FULL_LD  = 12'(BAUD_DIV - 1);
  localparam logic [11:0] HALF_LD  = 12'(HALF_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_q, state_d;
  logic [11:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_reg_q, shift_reg_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rdy_q, rdy_d;
  logic        frm_err_q, frm_err_d;
  logic        sync1_q, rx_s_q, rx_prev_q;
  logic        sample;
  logic        bit_val;

`ifdef UART_RX_MAJ_VOTE_EN
  // hist_q[0] is rx_s at baud_cnt==1, hist_q[1] at baud_cnt==2 when sampling
  logic [1:0] hist_q, hist_d;
  always_comb begin
    hist_d  = {hist_q[0], rx_s_q};
    bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
  end
  always_ff @(posedge clk) begin
    if (rst) hist_q <= 2'b00;
    else     hist_q <= hist_d;
  end
`else
  always_comb bit_val = rx_s_q;
`endif

  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_reg_d = shift_reg_q;
    rx_data_d   = rx_data_q;
    rdy_d       = rdy_q;
    frm_err_d   = frm_err_q;
    sample      = (state_q != IDLE) && (baud_cnt_q == 12'd0);

    if (state_q != IDLE)
      baud_cnt_d = sample ? FULL_LD : baud_cnt_q - 12'd1;

    if (bus.clr_rdy) begin
      rdy_d     = 1'b0;
      frm_err_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!rx_s_q && rx_prev_q) begin
          baud_cnt_d = HALF_LD;
          state_d    = START;
        end
      end
      START: begin
        if (sample) begin
          if (!bit_val) begin
            bit_cnt_d = 4'd0;
            state_d   = DATA;
          end else begin
            state_d   = IDLE;
          end
        end
      end
      DATA: begin
        if (sample) begin
          shift_reg_d = {bit_val, shift_reg_q[7:1]};
          bit_cnt_d   = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) state_d = STOP;
        end
      end
      STOP: begin
        // a stop-sample set wins over a same-cycle clr_rdy
        if (sample) begin
          rx_data_d = shift_reg_q;
          rdy_d     = 1'b1;
          frm_err_d = ~bit_val;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      baud_cnt_q  <= 12'd0;
      bit_cnt_q   <= 4'd0;
      shift_reg_q <= 8'h00;
      rx_data_q   <= 8'h00;
      rdy_q       <= 1'b0;
      frm_err_q   <= 1'b0;
      sync1_q     <= 1'b0;
      rx_s_q      <= 1'b0;
      rx_prev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_reg_q <= shift_reg_d;
      rx_data_q   <= rx_data_d;
      rdy_q       <= rdy_d;
      frm_err_q   <= frm_err_d;
      sync1_q     <= bus.rx;
      rx_s_q      <= sync1_q;
      rx_prev_q   <= rx_s_q;
    end
  end

  assign bus.rx_data = rx_data_q;
  assign bus.rdy     = rdy_q;
  assign bus.frm_err = frm_err_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, 8N1 format, LSB first. Mates with the team's uart_tx at the far end of the serial link. Default rate is 19200 baud from a 50 MHz clock.
- Synchronises the asynchronous rx line and detects the start-bit edge. Samples each bit at mid-bit, checks the stop bit, then presents the byte with a set/reset ready flag.

Parameters:
- BAUD_DIV, 2604, clocks per bit (50 MHz / 19200). Legal range 8..4095; the baud counter is 12 bits.
- HALF_DIV, BAUD_DIV/2, derived localparam (not overridable). Sets the delay from the start edge to the start-bit sample.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- rx  input  1  serial line, asynchronous, idles high
- clr_rdy  input  1  consumer acknowledge; clears rdy and frm_err
- rx_data  output  8  last received byte
- rdy  output  1  byte available (set/reset flag)
- frm_err  output  1  stop bit of the last byte sampled low

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; every flop resets on posedge clk when rst=1.
- Reset values: state=IDLE, rx_data=8'h00, rdy=0, frm_err=0, baud_cnt=0, bit_cnt=0, shift_reg=0.
- Synchroniser: rx passes through 2 flops, giving rx_s. A third flop holds rx_prev.
  - All three flops reset to 0, so the line must be seen high before any start is accepted.
- Start detect: rx_s==0 && rx_prev==1, in IDLE only.
- Baud counter:
  - Counts down.
  - Sample point when baud_cnt==0; baud_cnt then reloads BAUD_DIV-1.
  - Holds value in IDLE (no toggling when not receiving).
- State machine (IDLE, START, DATA, STOP):
  - IDLE: on start detect, baud_cnt <= HALF_DIV-1 and go to START.
  - START, at the sample point:
    - bit=0: bit_cnt <= 0, go to DATA.
    - bit=1: false start (glitch). Go to IDLE with no flag change.
  - DATA, at the sample point: shift_reg <= {bit, shift_reg[7:1]} and bit_cnt increments. After the 8th data bit (bit_cnt 7->8), go to STOP.
  - STOP, at the sample point:
    - rx_data <= shift_reg.
    - rdy <= 1.
    - frm_err <= ~bit.
    - Go to IDLE.
    - rx_data is updated even when a framing error occurs.
- Timing:
  - Consecutive samples are exactly BAUD_DIV clocks apart.
  - rdy and rx_data are valid on the cycle after the stop-bit sample.
  - A new start edge can be accepted on the cycle after returning to IDLE.
- Break / low stop bit: the edge detector requires the line to go high again before the next start. A held-low line never produces repeated frames.
- rdy / frm_err priority:
  - Set at stop sample beats clr_rdy in the same cycle (rdy=1, frm_err per sample).
  - Otherwise clr_rdy clears both.
  - rdy is not cleared by a new start.
- Overrun: a new byte overwrites rx_data while rdy=1. No error flag is raised.
- Reset mid-frame: the frame is aborted immediately and no rdy is produced. Reception restarts only after the line is seen high and then falls.

Optional Feature:
- Macro: UART_RX_MAJ_VOTE_EN.
- Defined: the bit value at each sample point is the 2-of-3 majority of rx_s at baud_cnt==2, 1 and 0. A single-cycle glitch at mid-bit is rejected.
- Undefined: the bit value is rx_s at baud_cnt==0 only.
- All other timing is identical with or without the macro.

Test Plan (BAUD_DIV=16 unless noted):
- Frame 0xA5 sent with a good stop bit -> rx_data=0xA5, rdy=1, frm_err=0. rdy rises 1 cycle after the stop sample, about 9.5 bit times after the start edge plus 2 synchroniser cycles.
- rx pulsed low for 4 clocks (< HALF_DIV=8) -> false start, returns to IDLE, rdy stays 0, rx_data unchanged.
- Frame 0x3C with stop bit 0, line then held low for 40 clocks -> rx_data=0x3C, rdy=1, frm_err=1. No second frame is received while the line stays low.
- clr_rdy asserted in the exact cycle rdy is set -> rdy=1 afterwards. clr_rdy on the next cycle -> rdy=0, frm_err=0.
- rst pulsed during data bit 4 of one frame, then a clean frame 0x81 -> only 0x81 is reported, one rdy pulse, frm_err=0.
- Frame 0xFF with a 1-cycle low glitch exactly at the bit-3 sample point -> with UART_RX_MAJ_VOTE_EN: rx_data=0xFF. Without the macro: rx_data=0xF7.
